// File: rtl/occt_read_arbiter_if.sv
// Bus bundle between the OCCT read arbiter, its search engines, the table loader
// and the OCCT SRAM macro. The slave side is the arbiter; master is everything around it.
interface occt_read_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int WIDTHS     = 1920,
    parameter int ADDR_WIDTH = 5
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr0;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr1;
    logic [NREQ-1:0]            req_ready;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [IDW-1:0]             rsp_id;
    logic                       rsp_err;
    logic [WIDTHS-1:0]          rsp_data0;
    logic [WIDTHS-1:0]          rsp_data1;

    logic                       ld_valid;
    logic                       ld_ready;
    logic [ADDR_WIDTH-1:0]      ld_addr;
    logic [WIDTHS-1:0]          ld_data;

    logic                       sram_wEn;
    logic [ADDR_WIDTH-1:0]      sram_wAddr;
    logic [WIDTHS-1:0]          sram_wData;
    logic                       sram_rEn;
    logic [ADDR_WIDTH-1:0]      sram_rAddr0;
    logic [ADDR_WIDTH-1:0]      sram_rAddr1;
    logic [WIDTHS-1:0]          sram_rData0;
    logic [WIDTHS-1:0]          sram_rData1;

    modport slave (
        input  req_valid, req_addr0, req_addr1,
        output req_ready,
        output rsp_valid, rsp_id, rsp_err, rsp_data0, rsp_data1,
        input  rsp_ready,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        output sram_wEn, sram_wAddr, sram_wData,
        output sram_rEn, sram_rAddr0, sram_rAddr1,
        input  sram_rData0, sram_rData1
    );

    modport master (
        output req_valid, req_addr0, req_addr1,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_err, rsp_data0, rsp_data1,
        output rsp_ready,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        input  sram_wEn, sram_wAddr, sram_wData,
        input  sram_rEn, sram_rAddr0, sram_rAddr1,
        output sram_rData0, sram_rData1
    );
endinterface

// File: rtl/occt_read_arbiter.sv
// Round-robin arbiter sharing the dual-read OCCT SRAM between NREQ search engines,
// with loader writes taking priority over reads; returns rows tagged by requester id.
module occt_read_arbiter #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int WIDTHS     = 1920,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 18
) (
    input  logic               clk,
    input  logic               rst,
    occt_read_arbiter_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDW-1:0]      LAST_IDX_C = IDW'(NREQ - 32'sd1);
    localparam logic [IDW-1:0]      ONE_IDX_C  = IDW'(32'sd1);
    localparam logic [NREQ-1:0]     ONE_HOT_C  = NREQ'(32'sd1);

    logic [IDW-1:0]        rr_ptr_r;
    logic [IDW-1:0]        grant_idx_s;
    logic                  found_s;
    logic                  issue_ok_s;
    logic                  grant_s;
    logic [ADDR_WIDTH-1:0] addr0_s;
    logic [ADDR_WIDTH-1:0] addr1_s;
    logic                  range_err_s;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [IDW-1:0]        rsp_id_r;

    // Round-robin search: first valid requester at or after rr_ptr_r, wrapping at NREQ
    always_comb begin
        int idx_v;
        logic [IDW-1:0] cand_v;
        idx_v       = 32'sd0;
        cand_v      = {IDW{1'b0}};
        found_s     = 1'b0;
        grant_idx_s = {IDW{1'b0}};
        for (int k = 32'sd0; k < NREQ; k++) begin
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= NREQ) begin
                idx_v = idx_v - NREQ;
            end else begin
                idx_v = idx_v;
            end
            cand_v = IDW'(idx_v);
            if (!found_s && bus.req_valid[cand_v]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_v;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Issue gating, granted addresses and range check
    always_comb begin
        issue_ok_s  = !rst && !bus.ld_valid && (!rsp_valid_r || bus.rsp_ready);
        grant_s     = issue_ok_s && found_s;
        addr0_s     = bus.req_addr0[int'(grant_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
        addr1_s     = bus.req_addr1[int'(grant_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
        range_err_s = ({1'b0, addr0_s} >= DEPTH_C) || ({1'b0, addr1_s} >= DEPTH_C);
    end

    // Grant, SRAM read/write port drive and response passthrough
    always_comb begin
        if (grant_s) begin
            bus.req_ready = ONE_HOT_C << grant_idx_s;
        end else begin
            bus.req_ready = {NREQ{1'b0}};
        end
        bus.sram_rEn    = grant_s;
        bus.sram_rAddr0 = addr0_s;
        bus.sram_rAddr1 = addr1_s;
        // Writes never coincide with a read, so a row written in T is read fresh in T+1
        bus.sram_wEn    = bus.ld_valid && !rst;
        bus.sram_wAddr  = bus.ld_addr;
        bus.sram_wData  = bus.ld_data;
        bus.ld_ready    = !rst;
        bus.rsp_valid   = rsp_valid_r;
        bus.rsp_id      = rsp_id_r;
        bus.rsp_err     = rsp_err_r;
        bus.rsp_data0   = bus.sram_rData0;
        bus.rsp_data1   = bus.sram_rData1;
    end

    // Round-robin pointer advances past the granted requester
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= {IDW{1'b0}};
        end else if (grant_s) begin
            rr_ptr_r <= (grant_idx_s == LAST_IDX_C) ? {IDW{1'b0}} : (grant_idx_s + ONE_IDX_C);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Response register; row data itself holds in the SRAM output registers while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (grant_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= grant_idx_s;
            rsp_err_r   <= range_err_s;
        end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= rsp_id_r;
            rsp_err_r   <= rsp_err_r;
        end else begin
            rsp_valid_r <= rsp_valid_r;
            rsp_id_r    <= rsp_id_r;
            rsp_err_r   <= rsp_err_r;
        end
    end
endmodule

// File: tb/tb_occt_read_arbiter.sv
// Directed bench for occt_read_arbiter with a behavioural registered-output SRAM model.
module tb_occt_read_arbiter;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int W     = 1920;
    localparam int AW    = 5;
    localparam int DEPTH = 18;
    localparam logic [W-1:0] PAT_P = {60{32'hDEAD_BEEF}};

    logic clk;
    logic rst;
    logic load_mem;
    logic [W-1:0] mem [0:31];
    int n_checks;
    int n_errors;

    occt_read_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .WIDTHS(W), .ADDR_WIDTH(AW)) bus ();

    occt_read_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .WIDTHS(W), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] row_pat(input int r);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W / 32; i++) begin
            v[i*32 +: 32] = 32'hA5A5_0000 ^ (32'(r) << 8) ^ 32'(i);
        end
        return v;
    endfunction

    // SRAM model: synchronous write, registered read outputs
    always @(posedge clk) begin
        if (load_mem) begin
            for (int r = 0; r < 32; r++) mem[r] <= row_pat(r);
        end else if (bus.sram_wEn) begin
            mem[bus.sram_wAddr] <= bus.sram_wData;
        end
        if (bus.sram_rEn) begin
            bus.sram_rData0 <= mem[bus.sram_rAddr0];
            bus.sram_rData1 <= mem[bus.sram_rAddr1];
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (low 96 bits)", tag, got[95:0], exp[95:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a0, input int a1);
        bus.req_addr0[i*AW +: AW] = AW'(a0);
        bus.req_addr1[i*AW +: AW] = AW'(a1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        load_mem      = 1'b1;
        bus.req_valid = '0;
        bus.req_addr0 = '0;
        bus.req_addr1 = '0;
        bus.rsp_ready = 1'b1;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        step();
        step();

        // Reset: no grant, no write, loader not ready even with requests present
        bus.req_valid = 4'hF;
        bus.ld_valid  = 1'b1;
        #1;
        check("rst_req_ready", W'(bus.req_ready), W'(4'b0000));
        check("rst_rEn", W'(bus.sram_rEn), W'(1'b0));
        check("rst_wEn", W'(bus.sram_wEn), W'(1'b0));
        check("rst_ld_ready", W'(bus.ld_ready), W'(1'b0));
        check("rst_rsp_valid", W'(bus.rsp_valid), W'(1'b0));
        bus.req_valid = '0;
        bus.ld_valid  = 1'b0;
        load_mem      = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("post_rst_rsp_valid", W'(bus.rsp_valid), W'(1'b0));
        check("post_rst_rsp_id", W'(bus.rsp_id), W'(2'd0));
        check("post_rst_rsp_err", W'(bus.rsp_err), W'(1'b0));
        check("post_rst_ld_ready", W'(bus.ld_ready), W'(1'b1));

        // Single read from requester 2
        set_req(2, 3, 7);
        bus.req_valid = 4'b0100;
        #1;
        check("single_ready", W'(bus.req_ready), W'(4'b0100));
        check("single_rEn", W'(bus.sram_rEn), W'(1'b1));
        check("single_rAddr0", W'(bus.sram_rAddr0), W'(5'd3));
        check("single_rAddr1", W'(bus.sram_rAddr1), W'(5'd7));
        step();
        bus.req_valid = '0;
        #1;
        check("single_rsp_valid", W'(bus.rsp_valid), W'(1'b1));
        check("single_rsp_id", W'(bus.rsp_id), W'(2'd2));
        check("single_rsp_err", W'(bus.rsp_err), W'(1'b0));
        check("single_data0", bus.rsp_data0, row_pat(3));
        check("single_data1", bus.rsp_data1, row_pat(7));

        // Reset so the round-robin starts from requester 0
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Round-robin with all requesters valid
        for (int i = 0; i < NREQ; i++) set_req(i, i, i + 8);
        bus.req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rr_ready", W'(bus.req_ready), W'(4'b0001 << (c % 4)));
            if (c > 0) begin
                check("rr_rsp_id", W'(bus.rsp_id), W'((c - 1) % 4));
                check("rr_data0", bus.rsp_data0, row_pat((c - 1) % 4));
                check("rr_data1", bus.rsp_data1, row_pat((c - 1) % 4 + 8));
            end
            step();
        end

        // Backpressure: response from requester 0 held for 3 cycles
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_rsp_valid", W'(bus.rsp_valid), W'(1'b1));
            check("bp_rsp_id", W'(bus.rsp_id), W'(2'd0));
            check("bp_data0", bus.rsp_data0, row_pat(0));
            check("bp_ready", W'(bus.req_ready), W'(4'b0000));
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", W'(bus.req_ready), W'(4'b0010));
        step();
        bus.req_valid = '0;
        #1;
        check("bp_next_valid", W'(bus.rsp_valid), W'(1'b1));
        check("bp_next_id", W'(bus.rsp_id), W'(2'd1));
        check("bp_next_data0", bus.rsp_data0, row_pat(1));
        step();
        check("bp_retired", W'(bus.rsp_valid), W'(1'b0));

        // Loader priority and write-then-read hazard on row 5
        set_req(0, 5, 5);
        bus.req_valid = 4'b0001;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 5'd5;
        bus.ld_data   = PAT_P;
        #1;
        check("ld_block_ready", W'(bus.req_ready), W'(4'b0000));
        check("ld_block_rEn", W'(bus.sram_rEn), W'(1'b0));
        check("ld_wEn", W'(bus.sram_wEn), W'(1'b1));
        check("ld_wAddr", W'(bus.sram_wAddr), W'(5'd5));
        step();
        bus.ld_valid = 1'b0;
        #1;
        check("ld_after_ready", W'(bus.req_ready), W'(4'b0001));
        step();
        // Response handshake coincides with another loader write: retire, no grant
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 5'd9;
        bus.ld_data  = ~PAT_P;
        #1;
        check("ld_rsp_id", W'(bus.rsp_id), W'(2'd0));
        check("ld_rsp_data0", bus.rsp_data0, PAT_P);
        check("ld_rsp_data1", bus.rsp_data1, PAT_P);
        check("hs_ld_ready", W'(bus.req_ready), W'(4'b0000));
        step();
        bus.ld_valid  = 1'b0;
        bus.req_valid = '0;
        #1;
        check("hs_ld_retired", W'(bus.rsp_valid), W'(1'b0));

        // Range errors and the DEPTH boundary
        set_req(1, 2, 20);
        bus.req_valid = 4'b0010;
        #1;
        check("oor_ready", W'(bus.req_ready), W'(4'b0010));
        step();
        set_req(2, 0, 17);
        bus.req_valid = 4'b0100;
        #1;
        check("oor_err", W'(bus.rsp_err), W'(1'b1));
        check("oor_id", W'(bus.rsp_id), W'(2'd1));
        check("r17_ready", W'(bus.req_ready), W'(4'b0100));
        step();
        set_req(3, 18, 0);
        bus.req_valid = 4'b1000;
        #1;
        check("r17_err", W'(bus.rsp_err), W'(1'b0));
        check("r17_id", W'(bus.rsp_id), W'(2'd2));
        check("r17_data1", bus.rsp_data1, row_pat(17));
        check("r18_ready", W'(bus.req_ready), W'(4'b1000));
        step();
        bus.req_valid = '0;
        #1;
        check("r18_err", W'(bus.rsp_err), W'(1'b1));
        check("r18_id", W'(bus.rsp_id), W'(2'd3));

        // Reset during a stalled response, with rr pointer moved to 2
        set_req(1, 4, 6);
        bus.req_valid = 4'b0010;
        #1;
        check("stall_ready", W'(bus.req_ready), W'(4'b0010));
        step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        step();
        check("stall_valid", W'(bus.rsp_valid), W'(1'b1));
        rst          = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 5'd4;
        bus.ld_data  = ~PAT_P;
        #1;
        check("mid_rst_wEn", W'(bus.sram_wEn), W'(1'b0));
        step();
        rst           = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        check("mid_rst_dropped", W'(bus.rsp_valid), W'(1'b0));
        set_req(0, 4, 1);
        set_req(2, 2, 2);
        bus.req_valid = 4'b0101;
        #1;
        check("mid_rst_rr0", W'(bus.req_ready), W'(4'b0001));
        step();
        bus.req_valid = '0;
        #1;
        check("mid_rst_id", W'(bus.rsp_id), W'(2'd0));
        check("mid_rst_row4", bus.rsp_data0, row_pat(4));
        check("mid_rst_row1", bus.rsp_data1, row_pat(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/occt_read_arbiter.md
# occt_read_arbiter

Shares the dual-read-port occurrence-table (OCCT) SRAM between NREQ backward-search engines and one table loader. Each cycle it grants at most one search request a paired row read (top/bottom pointer rows on rData0/rData1), returns the rows tagged with the requester id, and gives loader writes priority over reads. The block sits directly in front of the OCCT SRAM instance and drives all of its control and address pins.

## Interface
- NREQ, 4: number of search-engine requesters (2..8)
- IDW, 2: requester id width, ceil(log2(NREQ)), minimum 1
- WIDTHS, 1920: OCCT row width in bits
- ADDR_WIDTH, 5: row address width
- DEPTH, 18: number of valid rows; addresses ≥ DEPTH are out of range

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester read request
- req_addr0  in  NREQ*ADDR_WIDTH  top-pointer row, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_addr1  in  NREQ*ADDR_WIDTH  bottom-pointer row, same packing
- req_ready  out  NREQ  one-hot grant; request i is accepted in a cycle where req_valid[i] && req_ready[i]
- rsp_valid  out  1  response rows valid
- rsp_ready  in  1  response consumer accepts
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_err  out  1  either address of that request was ≥ DEPTH
- rsp_data0, rsp_data1  out  WIDTHS  rows; wired directly from sram_rData0/1
- ld_valid  in  1  loader write request
- ld_ready  out  1  constant 1 outside reset
- ld_addr  in  ADDR_WIDTH; ld_data  in  WIDTHS
- sram_wEn, sram_wAddr, sram_wData  out  1/ADDR_WIDTH/WIDTHS  SRAM write port
- sram_rEn, sram_rAddr0, sram_rAddr1  out  1/ADDR_WIDTH/ADDR_WIDTH  SRAM read port
- sram_rData0, sram_rData1  in  WIDTHS  SRAM registered read data

## Operation
- Issue condition: issue_ok = !rst && !ld_valid && (!rsp_valid || rsp_ready).
- Arbitration: round-robin over the req_valid bits, starting the search at rr_ptr. The first valid index at or after rr_ptr (modulo NREQ) wins. Arbitration is combinational.
- On a grant to requester g:
  - req_ready = one-hot(g) and sram_rEn = 1.
  - sram_rAddr0/1 = requester g's addr0/addr1.
  - rr_ptr <= (g+1) mod NREQ on the clock edge.
- With no grant: req_ready = 0 and sram_rEn = 0. rr_ptr holds.
- Loader writes:
  - sram_wEn = ld_valid && !rst; sram_wAddr = ld_addr; sram_wData = ld_data. The write port is a combinational passthrough.
  - A cycle with ld_valid never issues a read. This avoids same-cycle read/write returning stale rows.
- Response register, updated on the clock edge:
  - Grant this cycle: rsp_valid <= 1, rsp_id <= g, rsp_err <= (addr0 ≥ DEPTH) || (addr1 ≥ DEPTH).
  - No grant and rsp_ready: rsp_valid <= 0.
  - No grant and !rsp_ready: rsp_valid, rsp_id and rsp_err hold.
- Data hold: rsp_data is stable while stalled because the SRAM output registers only change when sram_rEn = 1.
- Out-of-range requests are still granted. The row data they return is undefined, and only rsp_err is meaningful.
- The address compare is unsigned, ADDR_WIDTH bits against DEPTH.

## Timing
- Reset values (while rst = 1 and on the first cycle after): rsp_valid 0, rsp_id 0, rsp_err 0, rr_ptr 0. While rst = 1: req_ready 0, sram_rEn 0, sram_wEn 0, ld_ready 0.
- Read latency: a grant in cycle T gives rsp_valid = 1 in T+1, with rsp_data0/1 = SRAM rows addressed in T.
- Throughput: one read per cycle while rsp_ready = 1 and ld_valid = 0.
- Back-to-back responses: a grant in the same cycle as a response handshake is legal. The new response appears in the next cycle.
- Backpressure: while rsp_valid && !rsp_ready, no grant is made. The response and its data hold unchanged.
- Loader priority: ld_valid blocks reads for that cycle only. A write to row A in T is visible to a read granted in T+1 or later.
- Simultaneous handshake and loader write: if rsp_valid && rsp_ready && ld_valid, the response retires (rsp_valid <= 0) and no new grant is made.
- Reset mid-operation: a pending response is dropped (rsp_valid <= 0 on the rst edge) and rr_ptr returns to 0. No SRAM write occurs during rst.

## Test plan
- Single read: requester 2 requests addr0 = 3, addr1 = 7 → granted in T; in T+1 rsp_valid = 1, rsp_id = 2, rsp_data0 = row 3, rsp_data1 = row 7, rsp_err = 0.
- Round-robin: all four requesters held valid, rsp_ready = 1 → grant order 0, 1, 2, 3, 0, one per cycle. Responses arrive in the same order, one cycle later.
- Backpressure: rsp_ready = 0 for 3 cycles after a response → rsp_valid, rsp_id and rsp_data are stable, all req_ready = 0. Raising rsp_ready retires the response and grants the next requester in the same cycle.
- Loader priority and hazard: ld_valid writes pattern P to row 5 in T while requester 0 requests row 5 → no grant in T; grant in T+1; response in T+2 returns P.
- Range error: addr1 = 20 with DEPTH = 18 → granted normally; response has rsp_err = 1. A following request with addr1 = 17 has rsp_err = 0.
- Reset mid-stall: response pending with rsp_ready = 0, rst asserted for 1 cycle → rsp_valid = 0 after the rst edge. The next grant starts at requester 0 even if rr_ptr was previously 2.
